fdiv_iter: RTL and testbench

Iterative single-precision FP divider, the inverse operation to the team's pipelined FP multiplier in the FPU. It computes result = input_a / input_b with a radix-2 restoring mantissa divider, using a start/ready/valid handshake and fixed latency. Denormal handling matches the multiplier: denormals are flushed to zero. Outputs go to the FPU writeback mux.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fdiv_mant_divider.sv | 50 +++++
 rtl/fdiv_iter.sv | 129 ++++++++++++
 tb/tb_fdiv_iter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP32 types, constants and divider state encoding
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam int          FP_BIAS     = 127;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
    localparam int          FDIV_QBITS  = 26;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND
    } fdiv_state_t;

endpackage

// File: rtl/fdiv_mant_divider.sv
// fdiv_mant_divider: radix-2 restoring divider producing one quotient bit per step
module fdiv_mant_divider
    import fpu_pkg::*;
#(
    parameter int QBITS = FDIV_QBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [23:0]      ma,
    input  logic [23:0]      mb,
    output logic [QBITS-1:0] q,
    output logic             rem_nz,
    output logic             done
);

    logic [24:0] r;
    logic [23:0] d;
    logic [4:0]  cnt;
    logic        ge;
    logic [24:0] diff;

    assign ge     = r >= {1'b0, d};
    assign diff   = r - {1'b0, d};
    assign rem_nz = |r;

    // After a subtraction r < d < 2^24, so the left shift never drops a set bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r    <= '0;
            d    <= '0;
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            r    <= {1'b0, ma};
            d    <= mb;
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (step && !done) begin
            r    <= (ge ? diff : r) << 1;
            q    <= {q[QBITS-2:0], ge};
            cnt  <= cnt + 5'd1;
            done <= cnt == 5'(QBITS - 1);
        end
    end

endmodule

// File: rtl/fdiv_iter.sv
// fdiv_iter: iterative FP32 divider with start/ready/valid handshake and fixed latency
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int QBITS    = FDIV_QBITS,
    parameter int EXP_BIAS = FP_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    output logic        ready,
    output logic        valid,
    output logic [31:0] result,
    output logic        div_by_zero
);

    fdiv_state_t      state, state_nx;
    fp32_t            op_a, op_b;
    logic             load, step, fin;
    logic [QBITS-1:0] q;
    logic             rem_nz, div_done;

    logic        sign;
    logic [9:0]  e_pre, e_rnd;
    logic [22:0] mant;
    logic        guard, sticky, inc;
    logic [23:0] mant_inc;
    logic [31:0] norm_res, res_nx;
    logic        dz_nx;
    logic        a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, qnan;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: DIV lingers one cycle past the last step so done is registered
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? DIV : IDLE;
            DIV:     state_nx = div_done ? ROUND : DIV;
            ROUND:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode of the FSM
    always_comb begin
        ready = state == IDLE;
        load  = ready && start;
        step  = state == DIV;
        fin   = state == ROUND;
    end

    // Operand capture on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (load) begin
            op_a <= input_a;
            op_b <= input_b;
        end
    end

    fdiv_mant_divider #(.QBITS(QBITS)) u_mant (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .ma     ({1'b1, input_a[22:0]}),
        .mb     ({1'b1, input_b[22:0]}),
        .q      (q),
        .rem_nz (rem_nz),
        .done   (div_done)
    );

    // Normalize, round to nearest even, clamp exponent and resolve special operands
    always_comb begin
        sign     = op_a.sign ^ op_b.sign;
        e_pre    = {2'b0, op_a.exp} - {2'b0, op_b.exp}
                   + (q[25] ? 10'(EXP_BIAS) : 10'(EXP_BIAS - 1));
        mant     = q[25] ? q[24:2] : q[23:1];
        guard    = q[25] ? q[1] : q[0];
        sticky   = q[25] ? (q[0] | rem_nz) : rem_nz;
        inc      = guard & (sticky | mant[0]);
        mant_inc = {1'b0, mant} + {23'd0, inc};
        e_rnd    = e_pre + {9'd0, mant_inc[23]};
        norm_res = $signed(e_rnd) < 10'sd1   ? {sign, 31'd0} :
                   $signed(e_rnd) > 10'sd254 ? {sign, FP_EXP_MAX, 23'd0} :
                                               {sign, e_rnd[7:0], mant_inc[22:0]};
        a_max    = op_a.exp == FP_EXP_MAX;
        b_max    = op_b.exp == FP_EXP_MAX;
        a_nan    = a_max & (|op_a.mant);
        b_nan    = b_max & (|op_b.mant);
        a_inf    = a_max & ~(|op_a.mant);
        b_inf    = b_max & ~(|op_b.mant);
        a_zero   = op_a.exp == 8'd0;
        b_zero   = op_b.exp == 8'd0;
        qnan     = a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero);
        res_nx   = qnan   ? FP_QNAN :
                   a_inf  ? {sign, FP_EXP_MAX, 23'd0} :
                   b_inf  ? {sign, 31'd0} :
                   b_zero ? {sign, FP_EXP_MAX, 23'd0} :
                   a_zero ? {sign, 31'd0} :
                            norm_res;
        dz_nx    = b_zero & ~a_zero & ~a_max;
    end

    // Result register: valid pulses for one cycle, result and flag hold until the next op
    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            valid <= fin;
            if (fin) begin
                result      <= res_nx;
                div_by_zero <= dz_nx;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// tb_fdiv_iter: directed and random self-checking bench for fdiv_iter
module tb_fdiv_iter;

    typedef struct packed {
        logic [31:0] res;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] input_a = '0;
    logic [31:0] input_b = '0;
    logic        ready, valid, div_by_zero;
    logic [31:0] result;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fdiv_iter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .input_a     (input_a),
        .input_b     (input_b),
        .ready       (ready),
        .valid       (valid),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Exact integer long division with RNE, for finite normal operands only
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic [23:0] ma, mb;
        logic [63:0] num, qq, rr;
        logic        s;
        int          e;
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        s  = a[31] ^ b[31];
        e  = int'(a[30:23]) - int'(b[30:23]);
        if (ma >= mb) begin
            num = {40'd0, ma} << 23;
            e   = e + 127;
        end else begin
            num = {40'd0, ma} << 24;
            e   = e + 126;
        end
        qq = num / {40'd0, mb};
        rr = num % {40'd0, mb};
        if (2 * rr > {40'd0, mb} || (2 * rr == {40'd0, mb} && qq[0])) qq = qq + 1;
        if (qq[24]) begin
            qq = qq >> 1;
            e  = e + 1;
        end
        if (e <= 0) return {s, 31'd0};
        if (e >= 255) return {s, 8'hFF, 23'd0};
        return {s, e[7:0], qq[22:0]};
    endfunction

    // Issue one op, optionally pulse a stray start at cycle extra_at, and check the outcome
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic dz, input int extra_at);
        int   k;
        int   ready_bad;
        exp_t x;
        sb.push_back('{res, dz});
        start   = 1'b1;
        input_a = a;
        input_b = b;
        @(negedge clk);
        start   = 1'b0;
        input_a = $urandom;
        input_b = $urandom;
        k = 0;
        ready_bad = 0;
        while (!valid && k < 40) begin
            if (ready) ready_bad++;
            if (k == extra_at - 1) begin
                start   = 1'b1;
                input_a = 32'h3F80_0000;
                input_b = 32'h3F80_0000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(k), 32'd28);
        chk({tag, " ready_low"}, 32'(ready_bad), 32'd0);
        x = sb.pop_front();
        if (valid) begin
            chk({tag, " result"}, result, x.res);
            chk({tag, " dz"}, {31'd0, div_by_zero}, {31'd0, x.dz});
        end
        @(negedge clk);
        chk({tag, " valid_pulse"}, {31'd0, valid}, 32'd0);
        chk({tag, " held"}, result, x.res);
    endtask

    initial begin
        int          vseen;
        logic [31:0] ra, rb, rs, rm;
        repeat (3) @(negedge clk);
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst valid", {31'd0, valid}, 32'd0);
        chk("rst result", result, 32'h0);
        chk("rst dz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("6div2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, -1);
        run_op("1div3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, -1);
        run_op("1div1", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, -1);
        run_op("neg_div0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, -1);
        run_op("nan_a", 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, -1);
        run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, -1);
        run_op("inf_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, -1);
        run_op("inf_a", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, -1);
        run_op("inf_b", 32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, -1);
        run_op("zero_a", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, -1);
        run_op("overflow", 32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 1'b0, -1);
        run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, -1);
        run_op("stray_start", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 5);

        start   = 1'b1;
        input_a = 32'h40C0_0000;
        input_b = 32'h4000_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort ready", {31'd0, ready}, 32'd1);
        chk("abort valid", {31'd0, valid}, 32'd0);
        vseen = 0;
        repeat (35) begin
            @(negedge clk);
            if (valid) vseen++;
        end
        chk("abort no_valid", 32'(vseen), 32'd0);
        run_op("after_abort", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, -1);

        for (int i = 0; i < 12; i++) begin
            rs = $urandom;
            rm = $urandom;
            ra = {rs[0], 8'($urandom_range(1, 254)), rm[22:0]};
            rm = $urandom;
            rb = {rs[1], 8'($urandom_range(1, 254)), rm[22:0]};
            run_op($sformatf("rand%0d", i), ra, rb, ref_div(ra, rb), 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
